vdu_crtc: RTL and testbench

Parametrised character-mode CRT controller. It is the next-generation video timing block of the VGA text pipeline, sitting between clockgen and the vram/vmatrix stages. It generates DE/HS/VS, the character-row scanline (R) and the VRAM fetch address (A). New over the fixed-timing controller: programmable timing and geometry, a hardware-scroll start address latched per frame, modulo-VRAM address wrap, and a blinking scanline-range cursor.

---
 rtl/vdu_pkg.sv | 51 +++++
 rtl/vdu_addr_gen.sv | 85 ++++++++
 rtl/vdu_crtc.sv | 201 ++++++++++++++++++++
 tb/tb_vdu_crtc.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vdu_pkg.sv
// -----------------------------------------------------------------------------
// vdu_pkg
// Shared timing helpers for the character-mode video pipeline (vdu_crtc,
// vmatrix). Provides the default 640x480 / 80x30 text constants and the
// functions that derive line/frame totals and sync window bounds from the
// porch and sync widths.
// -----------------------------------------------------------------------------
package vdu_pkg;

   // Default 640x480 text mode: 80x30 characters, 8x16 cells.
   localparam int DEF_H_ACTIVE     = 80;
   localparam int DEF_H_FP         = 2;
   localparam int DEF_H_SYNC       = 12;
   localparam int DEF_H_BP         = 6;
   localparam int DEF_ROWS         = 30;
   localparam int DEF_ROW_H        = 16;
   localparam int DEF_V_FP         = 10;
   localparam int DEF_V_SYNC       = 2;
   localparam int DEF_V_BP         = 33;
   localparam int DEF_ADDR_W       = 13;
   localparam int DEF_VRAM_DEPTH   = 2400;
   localparam int DEF_BLINK_FRAMES = 16;
   localparam int DEF_RA_W         = 5;

   // Character clocks per line.
   function automatic int h_tot(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   // Scanlines per frame.
   function automatic int v_tot(input int rows, input int row_h, input int fp, input int sync,
                                input int bp);
      return rows * row_h + fp + sync + bp;
   endfunction

   // First counter value inside the sync pulse.
   function automatic int sync_start(input int active, input int fp);
      return active + fp;
   endfunction

   // First counter value after the sync pulse.
   function automatic int sync_end(input int active, input int fp, input int sync);
      return active + fp + sync;
   endfunction

   // Counter width able to hold 0..n-1 (at least one bit).
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : vdu_pkg

// File: rtl/vdu_addr_gen.sv
// -----------------------------------------------------------------------------
// vdu_addr_gen
// VRAM fetch address generator. Holds the base address of the current
// character row, reloads it from start_addr_i at frame start and steps it by
// one row of characters after the last scanline of each row. Addresses wrap
// modulo VRAM_DEPTH using a single compare-and-subtract.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   ce_i            character-clock enable
//   frame_load_i    position is the frame origin (load start_addr_i)
//   row_adv_i       position is the last char clock of a row's last scanline
//   fetch_i         position is inside the visible part of the line
//   start_addr_i    top-left address of the frame (expected < VRAM_DEPTH)
//   hc_i            horizontal character counter
//   a_d_o           address that A takes on the next ce edge
//   a_o             registered VRAM address
// -----------------------------------------------------------------------------
module vdu_addr_gen #(
   parameter int ADDR_W     = 13,
   parameter int VRAM_DEPTH = 2400,
   parameter int H_ACTIVE   = 80,
   parameter int HC_W       = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce_i,
   input  logic              frame_load_i,
   input  logic              row_adv_i,
   input  logic              fetch_i,
   input  logic [ADDR_W-1:0] start_addr_i,
   input  logic [HC_W-1:0]   hc_i,
   output logic [ADDR_W-1:0] a_d_o,
   output logic [ADDR_W-1:0] a_o
);

   // One extra bit holds the carry of base + offset before the wrap.
   localparam logic [ADDR_W:0] DEPTH    = (ADDR_W+1)'(VRAM_DEPTH);
   localparam logic [ADDR_W:0] ROW_STEP = (ADDR_W+1)'(H_ACTIVE);

   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [ADDR_W-1:0] a_q;
   logic [ADDR_W-1:0] base_eff;

   // Both operands are below VRAM_DEPTH, so one subtraction completes the modulo.
   function automatic logic [ADDR_W-1:0] mod_wrap(input logic [ADDR_W:0] sum);
      logic [ADDR_W:0] adj;
      adj = (sum >= DEPTH) ? (sum - DEPTH) : sum;
      return adj[ADDR_W-1:0];
   endfunction

   // At the frame origin the new start address is used directly, so the very
   // first fetch of the frame already reflects it.
   assign base_eff = frame_load_i ? start_addr_i : row_base_q;

   // NOTE: every variable written in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      a_d_o      = a_q;
      row_base_d = row_base_q;
      if (fetch_i) begin
         a_d_o = mod_wrap({1'b0, base_eff} + (ADDR_W+1)'(hc_i));
      end
      if (frame_load_i) begin
         row_base_d = start_addr_i;
      end else if (row_adv_i) begin
         row_base_d = mod_wrap({1'b0, row_base_q} + ROW_STEP);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_base_q <= '0;
         a_q        <= '0;
      end else if (ce_i) begin
         row_base_q <= row_base_d;
         a_q        <= a_d_o;
      end
   end

   assign a_o = a_q;

endmodule : vdu_addr_gen

// File: rtl/vdu_crtc.sv
// -----------------------------------------------------------------------------
// vdu_crtc
// Parametrised character-mode CRT controller. Counts character clocks (hc),
// scanlines within a character row (ra) and scanlines per frame (vl), and
// produces registered display timing, the row scanline R, the VRAM fetch
// address A and a blinking scanline-range cursor. All outputs show the
// position that was current before the ce edge that updated them.
//
// Ports:
//   clk, rst_n        dot clock, asynchronous active-low reset
//   ce                character-clock enable; nothing advances while low
//   start_addr        top-left VRAM address, sampled at the frame origin
//   cursor_addr       cursor character address
//   cursor_en         cursor enable
//   cursor_first/last scanline range of the cursor within the row
//   cursor_blink      1 = blink with BLINK_FRAMES half-period, 0 = steady
//   DE, HS, VS        display enable, horizontal / vertical sync
//   R                 scanline within the character row (0 in vertical blank)
//   A                 VRAM address
//   cursor            cursor active at the current character
//   frame_start       high for the ce cycle that shows the frame origin
// -----------------------------------------------------------------------------
module vdu_crtc
   import vdu_pkg::*;
#(
   parameter int H_ACTIVE     = DEF_H_ACTIVE,
   parameter int H_FP         = DEF_H_FP,
   parameter int H_SYNC       = DEF_H_SYNC,
   parameter int H_BP         = DEF_H_BP,
   parameter int ROWS         = DEF_ROWS,
   parameter int ROW_H        = DEF_ROW_H,
   parameter int V_FP         = DEF_V_FP,
   parameter int V_SYNC       = DEF_V_SYNC,
   parameter int V_BP         = DEF_V_BP,
   parameter bit HS_POL       = 1'b0,
   parameter bit VS_POL       = 1'b0,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int VRAM_DEPTH   = DEF_VRAM_DEPTH,
   parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
   parameter int RA_W         = DEF_RA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] cursor_addr,
   input  logic              cursor_en,
   input  logic [RA_W-1:0]   cursor_first,
   input  logic [RA_W-1:0]   cursor_last,
   input  logic              cursor_blink,
   output logic              DE,
   output logic              HS,
   output logic              VS,
   output logic [RA_W-1:0]   R,
   output logic [ADDR_W-1:0] A,
   output logic              cursor,
   output logic              frame_start
);

   localparam int H_TOT = h_tot(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_VIS = ROWS * ROW_H;
   localparam int V_TOT = v_tot(ROWS, ROW_H, V_FP, V_SYNC, V_BP);
   localparam int HC_W  = cnt_w(H_TOT);
   localparam int VL_W  = cnt_w(V_TOT);
   localparam int FC_W  = cnt_w(BLINK_FRAMES + 1);

   localparam logic [HC_W-1:0] HC_LAST = HC_W'(H_TOT - 1);
   localparam logic [HC_W-1:0] HC_VIS  = HC_W'(H_ACTIVE);
   localparam logic [HC_W-1:0] HS_BEG  = HC_W'(sync_start(H_ACTIVE, H_FP));
   localparam logic [HC_W-1:0] HS_END  = HC_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
   localparam logic [VL_W-1:0] VL_LAST = VL_W'(V_TOT - 1);
   localparam logic [VL_W-1:0] VL_VIS  = VL_W'(V_VIS);
   localparam logic [VL_W-1:0] VS_BEG  = VL_W'(sync_start(V_VIS, V_FP));
   localparam logic [VL_W-1:0] VS_END  = VL_W'(sync_end(V_VIS, V_FP, V_SYNC));
   localparam logic [RA_W-1:0] RA_LAST = RA_W'(ROW_H - 1);
   localparam logic [FC_W-1:0] FC_TOP  = FC_W'(BLINK_FRAMES);

   // Position counters.
   logic [HC_W-1:0] hc_q, hc_d;
   logic [VL_W-1:0] vl_q, vl_d;
   logic [RA_W-1:0] ra_q, ra_d;

   // Blink state.
   logic [FC_W-1:0] fc_q, fc_d;
   logic            blink_vis_q, blink_vis_d;

   // Registered outputs.
   logic            de_q, de_d;
   logic            hs_q, hs_d;
   logic            vs_q, vs_d;
   logic [RA_W-1:0] r_q, r_d;
   logic            cursor_q, cursor_d;
   logic            fs_q;

   logic              line_end, at_origin, vis_line, row_adv;
   logic [ADDR_W-1:0] a_d;

   assign line_end  = (hc_q == HC_LAST);
   assign at_origin = (hc_q == '0) && (vl_q == '0);
   assign vis_line  = (vl_q < VL_VIS);
   assign row_adv   = line_end && (ra_q == RA_LAST) && vis_line;

   vdu_addr_gen #(
      .ADDR_W     (ADDR_W),
      .VRAM_DEPTH (VRAM_DEPTH),
      .H_ACTIVE   (H_ACTIVE),
      .HC_W       (HC_W)
   ) u_addr_gen (
      .clk          (clk),
      .rst_n        (rst_n),
      .ce_i         (ce),
      .frame_load_i (at_origin),
      .row_adv_i    (row_adv),
      .fetch_i      (hc_q < HC_VIS),
      .start_addr_i (start_addr),
      .hc_i         (hc_q),
      .a_d_o        (a_d),
      .a_o          (A)
   );

   // Counter advance. ra restarts with the frame so a frame height that is
   // not a multiple of ROW_H still begins every frame on scanline 0.
   always_comb begin
      hc_d = hc_q + 1'b1;
      vl_d = vl_q;
      ra_d = ra_q;
      if (line_end) begin
         hc_d = '0;
         if (vl_q == VL_LAST) begin
            vl_d = '0;
            ra_d = '0;
         end else begin
            vl_d = vl_q + 1'b1;
            ra_d = (ra_q == RA_LAST) ? '0 : ra_q + 1'b1;
         end
      end
   end

   // Blink: fc counts frame starts; the toggle happens on the start of frame
   // BLINK_FRAMES, 2*BLINK_FRAMES, ... so frames 0..BLINK_FRAMES-1 are visible.
   always_comb begin
      fc_d        = fc_q;
      blink_vis_d = blink_vis_q;
      if (at_origin) begin
         if (fc_q == FC_TOP) begin
            fc_d        = FC_W'(1);
            blink_vis_d = !blink_vis_q;
         end else begin
            fc_d = fc_q + 1'b1;
         end
      end
   end

   // Output decode from the pre-edge position. The cursor uses the next-state
   // DE/R/A so it lines up with them in the same output cycle.
   always_comb begin
      de_d     = (hc_q < HC_VIS) && vis_line;
      hs_d     = ((hc_q >= HS_BEG) && (hc_q < HS_END)) ? HS_POL : !HS_POL;
      vs_d     = ((vl_q >= VS_BEG) && (vl_q < VS_END)) ? VS_POL : !VS_POL;
      r_d      = vis_line ? ra_q : '0;
      cursor_d = de_d && cursor_en && (a_d == cursor_addr)
                 && (cursor_first <= r_d) && (r_d <= cursor_last)
                 && (!cursor_blink || blink_vis_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hc_q        <= '0;
         vl_q        <= '0;
         ra_q        <= '0;
         fc_q        <= '0;
         blink_vis_q <= 1'b1;
         de_q        <= 1'b0;
         hs_q        <= !HS_POL;
         vs_q        <= !VS_POL;
         r_q         <= '0;
         cursor_q    <= 1'b0;
         fs_q        <= 1'b0;
      end else if (ce) begin
         hc_q        <= hc_d;
         vl_q        <= vl_d;
         ra_q        <= ra_d;
         fc_q        <= fc_d;
         blink_vis_q <= blink_vis_d;
         de_q        <= de_d;
         hs_q        <= hs_d;
         vs_q        <= vs_d;
         r_q         <= r_d;
         cursor_q    <= cursor_d;
         fs_q        <= at_origin;
      end
   end

   assign DE          = de_q;
   assign HS          = hs_q;
   assign VS          = vs_q;
   assign R           = r_q;
   assign cursor      = cursor_q;
   assign frame_start = fs_q;

endmodule : vdu_crtc

// File: tb/tb_vdu_crtc.sv
// -----------------------------------------------------------------------------
// tb_vdu_crtc
// Bench for vdu_crtc with a reduced geometry (8x3 characters, 4-line cells,
// 12 char clocks per line, 17 lines per frame, 20-entry VRAM, 2-frame blink)
// so many frames fit in a short run. An independent position model predicts
// every output cycle; predictions are queued when a ce cycle is driven and
// compared when the outputs are sampled on the following falling edge.
// -----------------------------------------------------------------------------
module tb_vdu_crtc;

   localparam int HA  = 8;
   localparam int HFP = 1;
   localparam int HSY = 2;
   localparam int HBP = 1;
   localparam int HT  = HA + HFP + HSY + HBP;   // 12
   localparam int RWS = 3;
   localparam int RH  = 4;
   localparam int VFP = 1;
   localparam int VSY = 2;
   localparam int VBP = 2;
   localparam int VIS = RWS * RH;               // 12
   localparam int VT  = VIS + VFP + VSY + VBP;  // 17
   localparam int FR  = HT * VT;                // 204 ce per frame
   localparam int AW  = 5;
   localparam int DEP = 20;
   localparam int BF  = 2;
   localparam int RAW = 3;
   localparam bit HSP = 1'b0;
   localparam bit VSP = 1'b1;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           ce = 1'b0;
   logic [AW-1:0]  start_addr = '0;
   logic [AW-1:0]  cursor_addr = '0;
   logic           cursor_en = 1'b0;
   logic [RAW-1:0] cursor_first = '0;
   logic [RAW-1:0] cursor_last = '0;
   logic           cursor_blink = 1'b0;
   logic           de, hs, vs, cursor, frame_start;
   logic [RAW-1:0] r;
   logic [AW-1:0]  a;

   always #5 clk = ~clk;

   vdu_crtc #(
      .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
      .ROWS (RWS), .ROW_H (RH), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
      .HS_POL (HSP), .VS_POL (VSP), .ADDR_W (AW), .VRAM_DEPTH (DEP),
      .BLINK_FRAMES (BF), .RA_W (RAW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ce           (ce),
      .start_addr   (start_addr),
      .cursor_addr  (cursor_addr),
      .cursor_en    (cursor_en),
      .cursor_first (cursor_first),
      .cursor_last  (cursor_last),
      .cursor_blink (cursor_blink),
      .DE           (de),
      .HS           (hs),
      .VS           (vs),
      .R            (r),
      .A            (a),
      .cursor       (cursor),
      .frame_start  (frame_start)
   );

   typedef struct {
      logic           de, hs, vs;
      logic [RAW-1:0] r;
      logic [AW-1:0]  a;
      logic           cur, fs;
      bit             chk_a;
   } exp_t;

   typedef struct {
      logic [AW-1:0]  start;
      logic [AW-1:0]  cur;
      bit             en;
      logic [RAW-1:0] first, last;
      bit             blink;
      int             frames;
      int             exp_pulses;
   } vec_t;

   exp_t sb_q[$];
   exp_t last_exp;
   vec_t vecs[5];

   int n_checks = 0;
   int n_fail   = 0;
   int m_hc, m_vl, m_frame, m_base;
   int pulses;
   int fs_cnt;
   logic [AW-1:0] fs_a;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s @%0t: got 0x%h expected 0x%h", name, $time, got, want);
      end
   endtask

   // Bit order: {de, hs, vs, r[2:0], a[4:0], cursor, frame_start}.
   function automatic logic [31:0] pack(input logic de_v, input logic hs_v, input logic vs_v,
                                        input logic [RAW-1:0] r_v, input logic [AW-1:0] a_v,
                                        input logic cur_v, input logic fs_v);
      return {19'd0, de_v, hs_v, vs_v, r_v, a_v, cur_v, fs_v};
   endfunction

   task automatic model_reset();
      m_hc     = 0;
      m_vl     = 0;
      m_frame  = -1;
      m_base   = 0;
      last_exp = '{de: 1'b0, hs: !HSP, vs: !VSP, r: '0, a: '0, cur: 1'b0, fs: 1'b0, chk_a: 1'b1};
      sb_q.delete();
   endtask

   // Prediction for one ce edge from the current position and inputs.
   function automatic exp_t model_step();
      exp_t e;
      e.de = (m_hc < HA) && (m_vl < VIS);
      e.hs = (m_hc >= HA + HFP && m_hc < HA + HFP + HSY) ? HSP : !HSP;
      e.vs = (m_vl >= VIS + VFP && m_vl < VIS + VFP + VSY) ? VSP : !VSP;
      e.r  = (m_vl < VIS) ? RAW'(m_vl % RH) : '0;
      e.fs = (m_hc == 0) && (m_vl == 0);
      if (e.fs) begin
         m_frame++;
         m_base = int'(start_addr);
      end
      e.a     = AW'((m_base + (m_vl / RH) * HA + m_hc) % DEP);
      e.chk_a = e.de;
      e.cur   = e.de && cursor_en && (e.a == cursor_addr)
                && (cursor_first <= e.r) && (e.r <= cursor_last)
                && (!cursor_blink || ((m_frame / BF) % 2 == 0));
      m_hc++;
      if (m_hc == HT) begin
         m_hc = 0;
         m_vl = (m_vl == VT - 1) ? 0 : m_vl + 1;
      end
      return e;
   endfunction

   // Called on a falling edge: drive ce, queue the prediction, let one rising
   // edge pass and compare on the next falling edge. A ce=0 cycle predicts hold.
   task automatic tick(input bit ce_v);
      exp_t e;
      ce = ce_v;
      if (ce_v) last_exp = model_step();
      sb_q.push_back(last_exp);
      @(posedge clk);
      @(negedge clk);
      e = sb_q.pop_front();
      check("outputs",
            pack(de, hs, vs, r, e.chk_a ? a : '0, cursor, frame_start),
            pack(e.de, e.hs, e.vs, e.r, e.chk_a ? e.a : '0, e.cur, e.fs));
      if (ce_v && cursor) pulses++;
      if (ce_v && frame_start) begin
         fs_a = a;
         fs_cnt++;
      end
   endtask

   // Run n_ce enabled cycles with ce asserted on roughly ce_pct percent of clocks.
   task automatic run(input int n_ce, input int ce_pct);
      int done = 0;
      for (int i = 0; i < 4 * n_ce + 100 && done < n_ce; i++) begin
         bit c;
         c = ($urandom_range(99) < ce_pct);
         tick(c);
         if (c) done++;
      end
      check("run_budget", done, n_ce);
   endtask

   // Reset asserted between clock edges; outputs must change without a clock.
   task automatic do_reset();
      ce = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("async_reset", pack(de, hs, vs, r, a, cursor, frame_start),
               pack(1'b0, !HSP, !VSP, '0, '0, 1'b0, 1'b0));
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      pulses = 0;
      fs_cnt = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // start, cursor addr, en, first, last, blink, frames, expected cursor pulses
      vecs[0] = '{5'd0,  5'd9,  1'b1, 3'd2, 3'd3, 1'b0, 2, 4}; // row 1 col 1, 2 lines/frame
      vecs[1] = '{5'd18, 5'd19, 1'b1, 3'd0, 3'd3, 1'b0, 1, 8}; // wrapped start, 19 twice
      vecs[2] = '{5'd0,  5'd9,  1'b1, 3'd3, 3'd2, 1'b0, 1, 0}; // first > last
      vecs[3] = '{5'd0,  5'd9,  1'b0, 3'd0, 3'd3, 1'b0, 1, 0}; // disabled
      vecs[4] = '{5'd0,  5'd9,  1'b1, 3'd1, 3'd1, 1'b1, 6, 4}; // blink: frames 0,1,4,5

      model_reset();
      pulses = 0;
      fs_cnt = 0;

      for (int i = 0; i < 5; i++) begin
         start_addr   = vecs[i].start;
         cursor_addr  = vecs[i].cur;
         cursor_en    = vecs[i].en;
         cursor_first = vecs[i].first;
         cursor_last  = vecs[i].last;
         cursor_blink = vecs[i].blink;
         do_reset();
         run(vecs[i].frames * FR, 75);
         check($sformatf("cursor_pulses[%0d]", i), pulses, vecs[i].exp_pulses);
      end

      // start_addr changed mid-frame takes effect only at the next frame.
      cursor_en  = 1'b0;
      start_addr = 5'd2;
      do_reset();
      run(FR / 2, 100);
      check("fs_addr_frame0", fs_a, 5'd2);
      start_addr = 5'd16;
      run(FR - FR / 2, 100);
      check("fs_count_frame0", fs_cnt, 1);
      run(1, 100);
      check("fs_addr_frame1", fs_a, 5'd16);
      run(HT * RH * 2, 80);

      // Reset in the middle of the visible area, then restart at frame 0.
      start_addr = 5'd7;
      do_reset();
      run(8 * HT + 3, 100);
      check("mid_frame_de", de, 1'b1);
      do_reset();
      tick(1'b1);
      check("restart_fs", frame_start, 1'b1);
      check("restart_r", r, 3'd0);
      check("restart_a", a, 5'd7);
      run(HT * 5, 60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_vdu_crtc
